match_game_core: RTL and testbench

Parametrised game core for the dot-matrix match game. It compares a target action state against the player action state and awards points for sustained matches. It also runs a countdown game timer and a start/run/done state machine, and scans the active-low dot-matrix rows. It sits between the target/player sprite generators (which consume `row_idx`) and the seven-segment decoders (which consume the BCD score and time digits).

---
 rtl/match_game_core.sv | 159 +++++++++++++++
 tb/tb_match_game_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/match_game_core.sv
// match_game_core: match scoring, BCD countdown timer, IDLE/RUN/DONE control and active-low dot-matrix row scan.
// Define MATCH_STREAK_EN to make the 4th and later back-to-back score events worth 2 points each.
module match_game_core #(
    parameter int STATE_W       = 2,
    parameter int ROWS          = 8,
    parameter int SCAN_DIV      = 25000,
    parameter int HOLD_CYCLES   = 1000,
    parameter int TICKS_PER_SEC = 50000000,
    parameter int GAME_SECONDS  = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_btn,
    input  logic [STATE_W-1:0]      target_state,
    input  logic [STATE_W-1:0]      player_state,
    output logic [ROWS-1:0]         dot_row,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    running,
    output logic                    finished,
    output logic                    add_pulse,
    output logic [3:0]              score_ones,
    output logic [3:0]              score_tens,
    output logic [3:0]              time_ones,
    output logic [3:0]              time_tens
);
    localparam int RW = $clog2(ROWS);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] GS_T = 4'(GAME_SECONDS / 10);
    localparam logic [3:0] GS_O = 4'(GAME_SECONDS % 10);
    localparam logic [ROWS-1:0] ROW0 = {1'b1, {(ROWS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [SW-1:0]   scan_q, scan_d;
    logic [RW-1:0]   row_q, row_d;
    logic [ROWS-1:0] dot_row_q, dot_row_d;
    logic [7:0]      score_q, score_d, time_q, time_d;
    logic            add_pulse_q, add_pulse_d;
    logic            running_q, running_d, finished_q, finished_d;
    logic            start, stay_run, correct, tick_wrap, scan_wrap, bonus;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return v == 8'h99 ? v : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        return v == 8'h00 ? v : v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    // control FSM: start from IDLE/DONE, leave RUN once time reads 00 or score reads 99
    always_comb begin
        state_d = state_q;
        if (state_q == RUN) state_d = (time_q == 8'h00 || score_q == 8'h99) ? DONE : RUN;
        else if (start_btn) state_d = RUN;
        start      = state_q != RUN && start_btn;
        stay_run   = state_q == RUN && state_d == RUN;
        running_d  = state_d == RUN;
        finished_d = state_d == DONE;
    end

    // consecutive-match counter; pulses every HOLD_CYCLES matched cycles as long as the game continues
    always_comb begin
        correct     = state_q == RUN && target_state == player_state;
        add_pulse_d = correct && hold_q == HW'(HOLD_CYCLES - 1) && stay_run;
        hold_d      = (correct && hold_q != HW'(HOLD_CYCLES - 1)) ? hold_q + 1'b1 : '0;
    end

    // seconds countdown and BCD score; a pending pulse still lands on the cycle RUN is left
    always_comb begin
        tick_wrap = stay_run && tick_q == TW'(TICKS_PER_SEC - 1);
        tick_d    = (stay_run && !tick_wrap) ? tick_q + 1'b1 : '0;
        time_d    = start ? {GS_T, GS_O} : tick_wrap ? bcd_dec(time_q) : time_q;
        score_d   = start ? 8'h00 :
                    (state_q == RUN && add_pulse_q) ? (bonus ? bcd_inc(bcd_inc(score_q)) : bcd_inc(score_q)) :
                    score_q;
    end

    // row scan: the first divider wrap after start lights row 0, later wraps step to the next row
    always_comb begin
        scan_wrap = scan_q == SW'(SCAN_DIV - 1);
        scan_d    = (stay_run && !scan_wrap) ? scan_q + 1'b1 : '0;
        row_d     = start ? '0 : row_q;
        dot_row_d = '1;
        if (stay_run) begin
            if (scan_wrap && !(&dot_row_q)) row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            dot_row_d = scan_wrap ? ~(ROW0 >> row_d) : dot_row_q;
        end
    end

`ifdef MATCH_STREAK_EN
    logic [1:0] streak_q, streak_d;
    logic       bonus_q, bonus_d;

    // back-to-back event count saturating at 3; the 4th and later events carry the bonus
    always_comb begin
        streak_d = !correct ? 2'd0 : (add_pulse_d && streak_q != 2'd3) ? streak_q + 2'd1 : streak_q;
        bonus_d  = add_pulse_d && streak_q == 2'd3;
    end

    // streak registers
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= 2'd0;
            bonus_q  <= 1'b0;
        end else begin
            streak_q <= streak_d;
            bonus_q  <= bonus_d;
        end
    end

    assign bonus = bonus_q;
`else
    assign bonus = 1'b0;
`endif

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            tick_q      <= '0;
            scan_q      <= '0;
            row_q       <= '0;
            dot_row_q   <= '1;
            score_q     <= 8'h00;
            time_q      <= {GS_T, GS_O};
            add_pulse_q <= 1'b0;
            running_q   <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            tick_q      <= tick_d;
            scan_q      <= scan_d;
            row_q       <= row_d;
            dot_row_q   <= dot_row_d;
            score_q     <= score_d;
            time_q      <= time_d;
            add_pulse_q <= add_pulse_d;
            running_q   <= running_d;
            finished_q  <= finished_d;
        end
    end

    assign dot_row    = dot_row_q;
    assign row_idx    = row_q;
    assign running    = running_q;
    assign finished   = finished_q;
    assign add_pulse  = add_pulse_q;
    assign score_tens = score_q[7:4];
    assign score_ones = score_q[3:0];
    assign time_tens  = time_q[7:4];
    assign time_ones  = time_q[3:0];
endmodule

// File: tb/tb_match_game_core.sv
// tb_match_game_core: vector table, directed corner sequences and randomized play against a behavioural model
module tb_match_game_core;
    localparam int HOLD = 4, TPS = 10, SDIV = 2, NR = 8, GS = 3;
`ifdef MATCH_STREAK_EN
    localparam bit STRK = 1'b1;
`else
    localparam bit STRK = 1'b0;
`endif

    typedef struct {bit r; bit st; bit eq; int n; int score; int tsec; bit run; bit fin;} vec_t;

    logic       clk = 1'b0;
    logic       reset, start_btn;
    logic [1:0] target_state, player_state;
    logic [7:0] dot_row;
    logic [2:0] row_idx;
    logic       running, finished, add_pulse;
    logic [3:0] score_ones, score_tens, time_ones, time_tens;

    logic       b_reset, b_start;
    logic [1:0] b_tgt, b_ply, b_row;
    logic [3:0] b_dot, b_so, b_st, b_to, b_tt;
    logic       b_running, b_finished, b_add_pulse;

    int checks = 0, failures = 0;

    // model state: phase 0 idle, 1 run, 2 done; cycles spent in RUN; current matched-sample run length
    int m_phase, m_score, m_cyc, m_run, m_row;
    bit m_pulse, m_bonus;

    match_game_core #(.STATE_W(2), .ROWS(NR), .SCAN_DIV(SDIV), .HOLD_CYCLES(HOLD),
                      .TICKS_PER_SEC(TPS), .GAME_SECONDS(GS)) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn),
        .target_state(target_state), .player_state(player_state),
        .dot_row(dot_row), .row_idx(row_idx), .running(running), .finished(finished),
        .add_pulse(add_pulse), .score_ones(score_ones), .score_tens(score_tens),
        .time_ones(time_ones), .time_tens(time_tens));

    match_game_core #(.STATE_W(2), .ROWS(4), .SCAN_DIV(3), .HOLD_CYCLES(1),
                      .TICKS_PER_SEC(1000), .GAME_SECONDS(99)) dut_b (
        .clk(clk), .reset(b_reset), .start_btn(b_start),
        .target_state(b_tgt), .player_state(b_ply),
        .dot_row(b_dot), .row_idx(b_row), .running(b_running), .finished(b_finished),
        .add_pulse(b_add_pulse), .score_ones(b_so), .score_tens(b_st),
        .time_ones(b_to), .time_tens(b_tt));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic int m_time();
        return (m_cyc / TPS >= GS) ? 0 : GS - m_cyc / TPS;
    endfunction

    function automatic logic [7:0] m_dot();
        return (m_phase == 1 && m_cyc >= SDIV) ? ~(8'h80 >> m_row) : 8'hFF;
    endfunction

    task automatic model(input bit r, input bit st, input bit eq);
        bit leave, np, nb;
        int inc;
        np = 0;
        nb = 0;
        if (r) begin
            m_phase = 0; m_score = 0; m_cyc = 0; m_run = 0; m_row = 0;
        end else if (m_phase == 1) begin
            leave = m_time() == 0 || m_score == 99;
            m_run = eq ? m_run + 1 : 0;
            if (eq && m_run % HOLD == 0 && !leave) begin
                np = 1;
                nb = STRK && (m_run / HOLD >= 4);
            end
            inc = m_bonus ? 2 : 1;
            if (m_pulse) m_score = (m_score + inc > 99) ? 99 : m_score + inc;
            if (leave) m_phase = 2;
            else begin
                m_cyc++;
                if (m_cyc % SDIV == 0) m_row = (m_cyc / SDIV - 1) % NR;
            end
        end else begin
            m_run = 0;
            if (st) begin
                m_phase = 1; m_score = 0; m_cyc = 0; m_row = 0;
            end
        end
        m_pulse = np;
        m_bonus = nb;
    endtask

    task automatic cmp_model();
        chk("running", running, m_phase == 1);
        chk("finished", finished, m_phase == 2);
        chk("add_pulse", add_pulse, m_pulse);
        chk("score", {score_tens, score_ones}, bcd(m_score));
        chk("time", {time_tens, time_ones}, bcd(m_time()));
        chk("row_idx", row_idx, m_row);
        chk("dot_row", dot_row, m_dot());
    endtask

    task automatic step(input bit r, input bit st, input bit eq);
        logic [1:0] t;
        t = 2'($urandom_range(0, 3));
        reset = r;
        start_btn = st;
        target_state = t;
        player_state = eq ? t : t ^ 2'($urandom_range(1, 3));
        @(posedge clk);
        model(r, st, eq);
        #1;
        cmp_model();
    endtask

    initial begin
        vec_t tbl[$];
        logic [7:0] walk [8];
        reset = 1'b1; start_btn = 1'b0; target_state = 2'd0; player_state = 2'd0;
        b_reset = 1'b1; b_start = 1'b0; b_tgt = 2'd0; b_ply = 2'd1;
        walk = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        tbl.push_back('{1'b1, 1'b0, 1'b0,  1, 0, 3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 50, 0, 3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 0, 3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 12, 2, 2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 3, 2, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0,  1, 0, 3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 0, 3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1,  3, 0, 3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 0, 3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1,  3, 0, 3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 0, 3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0,  5, 0, 2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 17, 0, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 0, 0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  5, 0, 0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 0, 3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 24, STRK ? 7 : 5, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1,  1, STRK ? 9 : 6, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  5, STRK ? 9 : 6, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, STRK ? 9 : 6, 0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 0, 3, 1'b1, 1'b0});

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].st, tbl[i].eq);
            chk($sformatf("vec%0d_score", i), {score_tens, score_ones}, bcd(tbl[i].score));
            chk($sformatf("vec%0d_time", i), {time_tens, time_ones}, bcd(tbl[i].tsec));
            chk($sformatf("vec%0d_running", i), running, tbl[i].run);
            chk($sformatf("vec%0d_finished", i), finished, tbl[i].fin);
        end

        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("hold_pulse", add_pulse, n % 4 == 0);
        end

        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("scan_first", dot_row, 8'hFF);
        for (int n = 1; n <= 30; n++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("scan_dot", dot_row, n < 2 ? 8'hFF : walk[(n / 2 - 1) % 8]);
            if (n >= 2) chk("scan_row", row_idx, (n / 2 - 1) % 8);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("scan_done_dot", dot_row, 8'hFF);

        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b1);
        chk("midreset_pulse_before", add_pulse, 1);
        step(1'b1, 1'b0, 1'b1);
        chk("midreset_pulse", add_pulse, 0);
        chk("midreset_running", running, 0);
        step(1'b0, 1'b0, 1'b1);
        chk("midreset_score", {score_tens, score_ones}, 8'h00);

        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 99) < 85);

        chk("b_reset_dot", b_dot, 4'hF);
        chk("b_reset_time", {b_tt, b_to}, 8'h99);
        b_reset = 1'b0;
        b_start = 1'b1;
        @(posedge clk); #1;
        chk("b_running", b_running, 1);
        b_start = 1'b0;
        b_tgt = 2'd1;
        b_ply = 2'd1;
        @(posedge clk); #1;
        chk("b_first_pulse", b_add_pulse, 1);
        @(posedge clk); #1;
        chk("b_score_one", {b_st, b_so}, 8'h01);
        repeat (110) @(posedge clk);
        #1;
        chk("b_finished", b_finished, 1);
        chk("b_running_end", b_running, 0);
        chk("b_score_sat", {b_st, b_so}, 8'h99);
        chk("b_time_end", {b_tt, b_to}, 8'h99);
        chk("b_dot_end", b_dot, 4'hF);
        chk("b_pulse_end", b_add_pulse, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
